settings_bank: RTL and testbench
================================

Name: settings_bank

Overview:
- Parametrised successor to the settings register file in the communication-and-control block.
- Exposes a read-only region (live status words from other blocks) and a writable region through one address/data port.
- Writable region is double-buffered: host writes land in shadow registers, and consumers see active registers only after a commit, so multi-word updates apply atomically.
- A sequenced restore operation reloads parameter defaults, one word per cycle, then applies them.

Parameters:
- MEMORY_WIDTH, 32, bit width of every word.
- ROM_MEMORY_LENGTH, 16, number of read-only words, min 1.
- RAM_MEMORY_LENGTH, 8, number of writable words, min 1.
- RAM_DEFAULTS, {RAM_MEMORY_LENGTH*MEMORY_WIDTH{1'b0}}, flat default vector; word i is bits [i*W +: W].
- ADDR_WIDTH (localparam), $clog2(ROM_MEMORY_LENGTH+RAM_MEMORY_LENGTH).

Ports:
- clk, input, 1, single clock; all logic on rising edge.
- rstb, input, 1, reset; synchronous, active-low.
- wen, input, 1, write request for this cycle.
- ren, input, 1, read request for this cycle.
- addr, input, ADDR_WIDTH, word address.
- data_in, input, MEMORY_WIDTH, write data.
- data_out, output, MEMORY_WIDTH, registered read data.
- rvalid, output, 1, data_out valid, 1-cycle pulse.
- err, output, 1, illegal-access pulse.
- commit, input, 1, copy shadow to active.
- restore, input, 1, start the default-restore sequence.
- busy, output, 1, restore in progress.
- pending, output, 1, shadow written since last commit/restore.
- rom_data, input, ROM_MEMORY_LENGTH*MEMORY_WIDTH, flat read-only words.
- ram_data_out, output, RAM_MEMORY_LENGTH*MEMORY_WIDTH, flat active words.

Behaviour:
- Address map:
  - 0..ROM_MEMORY_LENGTH-1: ROM region.
  - ROM_MEMORY_LENGTH..ROM_MEMORY_LENGTH+RAM_MEMORY_LENGTH-1: RAM region, index = addr-ROM_MEMORY_LENGTH.
  - All higher addresses: invalid.
- Reset (rstb low at an edge):
  - shadow and active both load RAM_DEFAULTS.
  - data_out=0, rvalid=0, err=0, busy=0, pending=0, FSM to IDLE.
  - Reset during a restore aborts it; the defaults are applied by the reset itself.
- Write (wen=1, busy=0, RAM address): shadow[index]<=data_in at the edge; pending<=1. Active registers are unchanged.
- Read (ren=1): at the edge, data_out<=word and rvalid<=1 for one cycle. Latency is 1 cycle.
  - ROM address returns the rom_data slice sampled at that edge.
  - RAM address returns the shadow value before any write in the same cycle (read-before-write).
  - Invalid address returns 0 with err.
  - Reads are legal while busy.
  - ren=0 leaves data_out holding its value; rvalid=0.
- wen and ren in the same cycle: both are performed independently.
- err is a 1-cycle pulse the cycle after any of these (multiple causes give a single pulse):
  - wen to a ROM or invalid address (write dropped).
  - wen while busy (write dropped).
  - ren to an invalid address.
  - commit or restore while busy (request dropped).
  - commit and restore in the same IDLE cycle (restore wins, commit dropped).
- Commit (commit=1, busy=0, no restore):
  - All active<=shadow in one edge; pending<=0.
  - If wen hits the same cycle: the write lands in shadow, active takes the pre-write shadow, and pending stays 1.
- Restore FSM:
  - IDLE: on restore=1, go to RESTORE with idx=0; busy<=1.
  - RESTORE: shadow[idx]<=RAM_DEFAULTS word idx; idx increments. When idx==RAM_MEMORY_LENGTH-1, go to APPLY.
  - APPLY: active<=shadow (all defaults); pending<=0; busy<=0; go to IDLE.
  - busy is high for exactly RAM_MEMORY_LENGTH+1 cycles, from the cycle after restore is sampled through the APPLY cycle.
  - Active registers do not change until APPLY.
- idx width: $clog2(RAM_MEMORY_LENGTH), min 1 bit. No wrap beyond the last index.

Test Plan:
- Bench config: W=32, ROM=16, RAM=8, RAM_DEFAULTS word i=0xA0+i, rom_data word i=i.
- Reset, then ren addr 5 -> next cycle data_out=5, rvalid=1; ren addr 16 -> data_out=0xA0; ram_data_out word0=0xA0, pending=0.
- wen addr 16 data 16, then ren addr 16 -> data_out=16, pending=1, ram_data_out word0 still 0xA0; commit -> next cycle word0=16, pending=0.
- wen addr 3, then wen addr 24 -> err pulses once per request; ROM and shadow are unchanged; ren addr 30 -> data_out=0, rvalid=1, err=1.
- wen addr 17 data 0x55 together with commit -> active word1 unchanged, shadow word1=0x55, pending=1; a second commit -> word1=0x55.
- Write 0x11 to all RAM words, commit, then restore:
  - busy high for 9 cycles; active stays 0x11 until APPLY, then word i=0xA0+i.
  - wen during busy -> err and no change.
- Assert rstb low during the third RESTORE cycle -> busy=0, all shadow and active=defaults, pending=0.

Source files
------------

// File: rtl/settings_bank.sv
// settings_bank: double-buffered settings register file with read-only status words and sequenced default restore
module settings_bank #(
  parameter int MEMORY_WIDTH = 32,
  parameter int ROM_MEMORY_LENGTH = 16,
  parameter int RAM_MEMORY_LENGTH = 8,
  parameter logic [RAM_MEMORY_LENGTH*MEMORY_WIDTH-1:0] RAM_DEFAULTS = '0,
  localparam int ADDR_WIDTH = $clog2(ROM_MEMORY_LENGTH + RAM_MEMORY_LENGTH)
) (
  input  logic                                        clk,
  input  logic                                        rstb,
  input  logic                                        wen,
  input  logic                                        ren,
  input  logic [ADDR_WIDTH-1:0]                       addr,
  input  logic [MEMORY_WIDTH-1:0]                     data_in,
  output logic [MEMORY_WIDTH-1:0]                     data_out,
  output logic                                        rvalid,
  output logic                                        err,
  input  logic                                        commit,
  input  logic                                        restore,
  output logic                                        busy,
  output logic                                        pending,
  input  logic [ROM_MEMORY_LENGTH*MEMORY_WIDTH-1:0]   rom_data,
  output logic [RAM_MEMORY_LENGTH*MEMORY_WIDTH-1:0]   ram_data_out
);
  localparam int IW = RAM_MEMORY_LENGTH > 1 ? $clog2(RAM_MEMORY_LENGTH) : 1;
  typedef enum logic [1:0] {IDLE, RESTORE, APPLY} state_t;
  state_t state, state_n;
  logic [IW-1:0] idx, idx_n;
  logic [MEMORY_WIDTH-1:0] shadow [RAM_MEMORY_LENGTH];
  logic [MEMORY_WIDTH-1:0] active [RAM_MEMORY_LENGTH];
  logic [MEMORY_WIDTH-1:0] rd_word;
  logic is_rom, is_ram, do_write, do_commit, do_apply, err_n;
  int a;
  assign a = int'(addr);
  assign is_rom = a < ROM_MEMORY_LENGTH;
  assign is_ram = a >= ROM_MEMORY_LENGTH && a < ROM_MEMORY_LENGTH + RAM_MEMORY_LENGTH;
  assign busy = state != IDLE;
  assign do_write = wen && !busy && is_ram;
  assign do_commit = commit && !busy && !restore;
  assign do_apply = state == APPLY;
  assign err_n = (wen && (busy || !is_ram)) || (ren && !is_rom && !is_ram) ||
                 (busy && (commit || restore)) || (!busy && commit && restore);
  for (genvar g = 0; g < RAM_MEMORY_LENGTH; g++) begin : g_out
    assign ram_data_out[g*MEMORY_WIDTH +: MEMORY_WIDTH] = active[g];
  end
  // RAM reads see shadow before this cycle's write lands
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < ROM_MEMORY_LENGTH; i++)
      if (a == i) rd_word = rom_data[i*MEMORY_WIDTH +: MEMORY_WIDTH];
    for (int i = 0; i < RAM_MEMORY_LENGTH; i++)
      if (a == ROM_MEMORY_LENGTH + i) rd_word = shadow[i];
  end
  always_comb begin
    state_n = state;
    idx_n = idx;
    case (state)
      IDLE: if (restore) begin
        state_n = RESTORE;
        idx_n = '0;
      end
      RESTORE: if (int'(idx) == RAM_MEMORY_LENGTH - 1) state_n = APPLY;
               else idx_n = idx + 1'b1;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rstb) begin
      state <= IDLE;
      idx <= '0;
      data_out <= '0;
      rvalid <= 1'b0;
      err <= 1'b0;
      pending <= 1'b0;
      for (int i = 0; i < RAM_MEMORY_LENGTH; i++) begin
        shadow[i] <= RAM_DEFAULTS[i*MEMORY_WIDTH +: MEMORY_WIDTH];
        active[i] <= RAM_DEFAULTS[i*MEMORY_WIDTH +: MEMORY_WIDTH];
      end
    end else begin
      state <= state_n;
      idx <= idx_n;
      rvalid <= ren;
      if (ren) data_out <= rd_word;
      err <= err_n;
      pending <= do_write ? 1'b1 : (do_commit || do_apply) ? 1'b0 : pending;
      for (int i = 0; i < RAM_MEMORY_LENGTH; i++) begin
        if (do_commit || do_apply) active[i] <= shadow[i];
        if (state == RESTORE && int'(idx) == i) shadow[i] <= RAM_DEFAULTS[i*MEMORY_WIDTH +: MEMORY_WIDTH];
        else if (do_write && a == ROM_MEMORY_LENGTH + i) shadow[i] <= data_in;
      end
    end
  end
endmodule

// File: tb/tb_settings_bank.sv
// tb_settings_bank: directed plan plus randomized traffic against a behavioural model of settings_bank
module tb_settings_bank;
  localparam logic [255:0] DEF = {32'hA7, 32'hA6, 32'hA5, 32'hA4, 32'hA3, 32'hA2, 32'hA1, 32'hA0};
  logic clk = 0, rstb = 0, wen = 0, ren = 0, commit = 0, restore = 0;
  logic [4:0] addr = 0;
  logic [31:0] data_in = 0, data_out;
  logic rvalid, err, busy, pending;
  logic [511:0] rom_data;
  logic [255:0] ram_data_out;
  int checks = 0, failures = 0;
  logic [31:0] m_shadow [8], m_active [8], e_do;
  logic e_rv, e_err, m_busy, m_pending;
  int m_k, busy_cycles;

  settings_bank #(.MEMORY_WIDTH(32), .ROM_MEMORY_LENGTH(16), .RAM_MEMORY_LENGTH(8), .RAM_DEFAULTS(DEF)) dut (
    .clk(clk), .rstb(rstb), .wen(wen), .ren(ren), .addr(addr), .data_in(data_in),
    .data_out(data_out), .rvalid(rvalid), .err(err), .commit(commit), .restore(restore),
    .busy(busy), .pending(pending), .rom_data(rom_data), .ram_data_out(ram_data_out));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] flat_active();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = m_active[i];
    return v;
  endfunction

  task automatic step(input logic r_rstb, input logic r_wen, input logic r_ren, input logic [4:0] r_addr,
                      input logic [31:0] r_din, input logic r_commit, input logic r_restore);
    int x;
    bit in_rom, in_ram;
    rstb = r_rstb; wen = r_wen; ren = r_ren; addr = r_addr; data_in = r_din;
    commit = r_commit; restore = r_restore;
    x = int'(r_addr);
    in_rom = x < 16;
    in_ram = x >= 16 && x < 24;
    if (!r_rstb) begin
      for (int i = 0; i < 8; i++) begin
        m_shadow[i] = DEF[i*32 +: 32];
        m_active[i] = DEF[i*32 +: 32];
      end
      e_do = 0; e_rv = 0; e_err = 0; m_busy = 0; m_pending = 0;
    end else begin
      e_rv = r_ren;
      if (r_ren) e_do = in_rom ? rom_data[x*32 +: 32] : in_ram ? m_shadow[x-16] : 32'h0;
      e_err = (r_wen && (m_busy || !in_ram)) || (r_ren && !in_rom && !in_ram) ||
              (m_busy && (r_commit || r_restore)) || (!m_busy && r_commit && r_restore);
      if (m_busy) begin
        if (m_k < 8) begin
          m_shadow[m_k] = DEF[m_k*32 +: 32];
          m_k++;
        end else begin
          for (int i = 0; i < 8; i++) m_active[i] = m_shadow[i];
          m_pending = 0;
          m_busy = 0;
        end
      end else begin
        if (r_commit && !r_restore) begin
          for (int i = 0; i < 8; i++) m_active[i] = m_shadow[i];
          m_pending = 0;
        end
        if (r_wen && in_ram) begin
          m_shadow[x-16] = r_din;
          m_pending = 1;
        end
        if (r_restore) begin
          m_busy = 1;
          m_k = 0;
        end
      end
    end
    @(posedge clk);
    #1;
    chk("data_out", data_out, e_do);
    chk("rvalid", rvalid, e_rv);
    chk("err", err, e_err);
    chk("busy", busy, m_busy);
    chk("pending", pending, m_pending);
    chk("ram_data_out", ram_data_out, flat_active());
    if (busy) busy_cycles++;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rom_data[i*32 +: 32] = i;
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("rst_active", ram_data_out, DEF);
    step(1, 0, 1, 5, 0, 0, 0);
    chk("rd_rom5", data_out, 5);
    step(1, 0, 1, 16, 0, 0, 0);
    chk("rd_ram0", data_out, 32'hA0);
    step(1, 1, 0, 16, 16, 0, 0);
    step(1, 0, 1, 16, 0, 0, 0);
    chk("rd_shadow0", data_out, 16);
    chk("active0_held", ram_data_out[31:0], 32'hA0);
    step(1, 0, 0, 0, 0, 1, 0);
    chk("commit0", ram_data_out[31:0], 16);
    step(1, 1, 0, 3, 32'hDEAD, 0, 0);
    chk("err_rom_wr", err, 1);
    step(1, 1, 0, 24, 32'hBEEF, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("err_single", err, 0);
    step(1, 0, 1, 3, 0, 0, 0);
    chk("rom3_intact", data_out, 3);
    step(1, 0, 1, 30, 0, 0, 0);
    chk("rd_invalid", data_out, 0);
    step(1, 1, 0, 17, 32'h55, 1, 0);
    chk("active1_pre", ram_data_out[63:32], 32'hA1);
    chk("pending_kept", pending, 1);
    step(1, 0, 0, 0, 0, 1, 0);
    chk("active1_post", ram_data_out[63:32], 32'h55);
    for (int i = 16; i < 24; i++) step(1, 1, 0, 5'(i), 32'h11, 0, 0);
    step(1, 0, 0, 0, 0, 1, 0);
    busy_cycles = 0;
    step(1, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) begin
      chk("active_held", ram_data_out[255:224], 32'h11);
      step(1, i == 3, i == 5, 19, 32'h99, 0, 0);
    end
    step(1, 0, 0, 0, 0, 0, 0);
    chk("busy_len", busy_cycles, 9);
    chk("restored", ram_data_out, DEF);
    step(1, 1, 0, 18, 32'h77, 0, 0);
    step(1, 0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("rst_abort_busy", busy, 0);
    chk("rst_abort_active", ram_data_out, DEF);
    step(1, 0, 1, 18, 0, 0, 0);
    chk("rst_abort_shadow", data_out, 32'hA2);
    for (int n = 0; n < 3000; n++) begin
      if (n % 100 == 0)
        for (int i = 0; i < 16; i++) rom_data[i*32 +: 32] = $urandom;
      step($urandom_range(0, 199) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
           5'($urandom_range(0, 31)), $urandom, $urandom_range(0, 9) == 0, $urandom_range(0, 24) == 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
